hyperbus_phy2r: RTL and testbench
=================================

Name: hyperbus_phy2r

Overview:
Read-data path of the HyperBus controller, the counterpart of the write-data path. It takes naturally aligned PHY read words (16*NumPhys bits, 2*NumPhys bytes) from the PHY/CDC FIFO side and assembles AXI R beats of AxiDataWidth bits. Each byte lands in the AXI byte lane given by its address, honouring the latched AXI size, start address and length. Narrow beats (2^size < PHY word) split one PHY word into several AXI beats. Wide beats gather several PHY words into one AXI beat.

Parameters:
AxiDataWidth, 64, AXI R data width in bits; must be >= 16*NumPhys and a power of two.
BurstLength, 8, width of the len input (AXI burst length minus one).
AddrWidth, $clog2(AxiDataWidth/8), width of start_addr (byte offset within an AXI word).

Ports:
clk_i  in  1  clock.
rst_i  in  1  asynchronous, active-high reset.
trans_handshake  in  1  AXI AR/AW accepted; latches size, start_addr, len, is_a_write.
is_a_write  in  1  transaction is a write; this block starts only when 0.
size  in  3  AXI size (beat bytes = 2^size, with 2^size <= AxiDataWidth/8).
start_addr  in  AddrWidth  start byte offset within an AXI word.
len  in  BurstLength  number of AXI beats minus one.
phy_valid_i  in  1  PHY read word valid.
phy_ready_o  out  1  PHY read word accepted.
data_i  in  16*NumPhys  PHY read word, aligned to 2*NumPhys bytes.
last_i  in  1  last PHY word of the transfer (informational, see Behaviour).
axi_valid_o  out  1  R beat valid.
axi_ready_i  in  1  R beat ready.
data_o  out  AxiDataWidth  R data.
last_o  out  1  R last.

Behaviour:
- Reset: state Idle. phy_ready_o=0, axi_valid_o=0, last_o=0, data_o=0. All counters and the buffer are cleared. Reset mid-burst abandons the burst immediately; the next transaction starts clean.
- Latched on entry from Idle:
  - byte_idx = start_addr;
  - phy_ptr = start_addr aligned down to 2*NumPhys;
  - beats_left = len;
  - size.
- State Idle: both handshakes low. On trans_handshake & !is_a_write, go to Collect. trans_handshake outside Idle is ignored; upstream serialises transactions.
- State Collect: phy_ready_o=1, axi_valid_o=0.
  - On a PHY handshake, write data_i into buffer lanes [phy_ptr +: 2*NumPhys], then phy_ptr += 2*NumPhys (modulo AxiDataWidth/8).
  - If 2^size <= 2*NumPhys, go to Send after one word.
  - Otherwise go to Send once the new phy_ptr is aligned to 2^size; else stay in Collect.
- State Send: axi_valid_o=1, phy_ready_o=0. data_o = buffer. Lanes outside the active beat hold stale data (permitted by AXI). last_o = (beats_left==0).
  - On an R handshake with last_o=1, go to Idle.
  - Otherwise beats_left--, and next byte_idx = (byte_idx aligned down to 2^size) + 2^size, modulo AxiDataWidth/8.
  - If next byte_idx is not aligned to 2*NumPhys (the narrow beat is still inside the same PHY word), stay in Send.
  - Otherwise go to Collect.
- Latency: the first R beat is valid 1 cycle after the completing PHY handshake. Narrow back-to-back beats from one PHY word run at 1 per cycle.
- Backpressure: data_o and last_o stay stable while axi_valid_o=1 and axi_ready_i=0.
- Leftover PHY words:
  - last_i is not used for beat counting; len governs.
  - Any PHY word still arriving after the final R beat is consumed in Idle (phy_ready_o=1 when phy_valid_i=1) and discarded, so the CDC FIFO drains.
- Wrap: byte_idx and phy_ptr wrap modulo AxiDataWidth/8. beats_left never wraps because Send exits at 0.

Optional Feature:
HYPERBUS_PHY2R_ERR_EN.
- Defined: adds ports phy_error_i (in, 1, sideband of data_i) and resp_o (out, 2).
  - resp_o = 2'b10 (SLVERR) on every R beat whose bytes came from a PHY word with phy_error_i=1. The error stays sticky across narrow beats that reuse that word.
  - resp_o is also SLVERR on the final beat if last_i was seen before beats_left reached 0.
  - Otherwise resp_o = 2'b00. Reset value 2'b00.
- Undefined: neither port exists and errors are not tracked.

Decomposition:
- hyperbus_pkg holds:
  - NumPhys;
  - the state enum hyperbus_phy2r_state_t {Idle, Collect, Send};
  - the AXI RESP constants.
- One sub-module, hyperbus_axi_beat_cnt: byte_idx/beats_left update on handshake for a given size. It is shareable with the write path.

Test Plan:
Configuration: AxiDataWidth=64, NumPhys=2 (4-byte PHY word).
1. size=3, start_addr=0, len=1; PHY words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C -> beat0 0x0706050403020100, beat1 0x0F0E0D0C0B0A0908 with last_o=1; 4 PHY handshakes.
2. size=0, start_addr=1, len=2; PHY word 0x33221100 -> 3 consecutive beats with lane1=0x11, lane2=0x22, lane3=0x33; exactly one PHY handshake; last_o on beat 3.
3. size=1, start_addr=2, len=1; words 0xDDCCBBAA, 0x44332211 -> beat0 lanes[3:2]=0xDDCC, beat1 lanes[5:4]=0x2211 with last_o=1.
4. Case 1 with axi_ready_i held low 5 cycles on beat0 -> data_o and axi_valid_o stable, phy_ready_o=0 throughout, then completes normally.
5. rst_i pulsed during Collect of case 1 -> outputs 0 next edge; a fresh case 2 then passes.
6. With HYPERBUS_PHY2R_ERR_EN: case 2 with phy_error_i=1 on its word -> resp_o=2'b10 on all 3 beats; case 1 clean -> resp_o=2'b00.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// -----------------------------------------------------------------------------
// hyperbus_pkg
//   Shared definitions for the HyperBus controller data paths.
//   - NumPhys / PhyBytes: number of PHYs and the resulting PHY word size in bytes
//   - hyperbus_phy2r_state_t: read-path FSM states
//   - AXI RESP encodings
// -----------------------------------------------------------------------------
package hyperbus_pkg;

    localparam int unsigned NumPhys  = 2;
    localparam int unsigned PhyBytes = 2 * NumPhys;
    localparam int unsigned PhyWidth = 16 * NumPhys;

    typedef enum logic [1:0] {
        Idle,
        Collect,
        Send
    } hyperbus_phy2r_state_t;

    localparam logic [1:0] AxiRespOkay   = 2'b00;
    localparam logic [1:0] AxiRespSlvErr = 2'b10;

endpackage

// File: rtl/hyperbus_axi_beat_cnt.sv
// -----------------------------------------------------------------------------
// hyperbus_axi_beat_cnt
//   Tracks the byte index of the current AXI beat and the number of beats still
//   to go after it. Used by both the read and the write data paths.
//
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   load            latch start_addr / len at the start of a burst
//   step            advance to the next beat (AXI handshake, not the last beat)
//   start_addr      starting byte offset within an AXI word
//   len             number of beats minus one
//   size            AXI size of the burst (beat bytes = 2^size)
//   byte_idx        byte offset of the current beat
//   byte_idx_next   byte offset the next beat will use
//   beat_mask       2^size - 1, truncated to the offset width (all ones for a
//                   full-width beat)
//   beats_left      beats remaining after the current one
//   last            current beat is the final beat of the burst
// -----------------------------------------------------------------------------
module hyperbus_axi_beat_cnt #(
    parameter int unsigned AddrWidth   = 3,
    parameter int unsigned BurstLength = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load,
    input  logic                   step,
    input  logic [AddrWidth-1:0]   start_addr,
    input  logic [BurstLength-1:0] len,
    input  logic [2:0]             size,
    output logic [AddrWidth-1:0]   byte_idx,
    output logic [AddrWidth-1:0]   byte_idx_next,
    output logic [AddrWidth-1:0]   beat_mask,
    output logic [BurstLength-1:0] beats_left,
    output logic                   last
);

    logic [AddrWidth-1:0] beat_bytes;

    // A full-width beat shifts the one out of range, giving 0 bytes modulo the
    // AXI word; the mask then becomes all ones and alignment lands on 0.
    assign beat_bytes    = AddrWidth'(1) << size;
    assign beat_mask     = beat_bytes - AddrWidth'(1);
    assign byte_idx_next = (byte_idx & ~beat_mask) + beat_bytes;
    assign last          = (beats_left == '0);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_idx   <= '0;
            beats_left <= '0;
        end else if (load) begin
            byte_idx   <= start_addr;
            beats_left <= len;
        end else if (step) begin
            byte_idx   <= byte_idx_next;
            beats_left <= beats_left - BurstLength'(1);
        end
    end

endmodule

// File: rtl/hyperbus_phy2r.sv
// -----------------------------------------------------------------------------
// hyperbus_phy2r
//   HyperBus read-data path: gathers naturally aligned PHY read words into an
//   AXI-word buffer and emits AXI R beats. Narrow beats reuse one PHY word for
//   several beats; wide beats collect several PHY words per beat.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   trans_handshake   AR/AW accepted; size/start_addr/len/is_a_write are valid
//   is_a_write        transaction is a write (ignored by this block)
//   size              AXI size
//   start_addr        starting byte offset within an AXI word
//   len               AXI burst length minus one
//   phy_valid_i       PHY read word valid
//   phy_ready_o       PHY read word accepted
//   data_i            PHY read word
//   last_i            last PHY word of the transfer (beat counting uses len)
//   axi_valid_o       R beat valid
//   axi_ready_i       R beat ready
//   data_o            R data (lanes outside the active beat are stale)
//   last_o            R last
//
// Optional feature, macro HYPERBUS_PHY2R_ERR_EN:
//   phy_error_i       error sideband of data_i
//   resp_o            R resp; SLVERR for beats built from an errored PHY word,
//                     and on the final beat if last_i arrived early
// -----------------------------------------------------------------------------
module hyperbus_phy2r
    import hyperbus_pkg::*;
#(
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned BurstLength  = 8,
    parameter int unsigned AddrWidth    = $clog2(AxiDataWidth / 8)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    trans_handshake,
    input  logic                    is_a_write,
    input  logic [2:0]              size,
    input  logic [AddrWidth-1:0]    start_addr,
    input  logic [BurstLength-1:0]  len,
    input  logic                    phy_valid_i,
    output logic                    phy_ready_o,
    input  logic [PhyWidth-1:0]     data_i,
    input  logic                    last_i,
`ifdef HYPERBUS_PHY2R_ERR_EN
    input  logic                    phy_error_i,
    output logic [1:0]              resp_o,
`endif
    output logic                    axi_valid_o,
    input  logic                    axi_ready_i,
    output logic [AxiDataWidth-1:0] data_o,
    output logic                    last_o
);

    localparam int unsigned PhyLog = $clog2(PhyBytes);
    localparam logic [AddrWidth-1:0] PhyOffsetMask = AddrWidth'(PhyBytes - 1);
    localparam logic [AddrWidth-1:0] PhyStep       = AddrWidth'(PhyBytes);

    hyperbus_phy2r_state_t state;

    logic                    collect_q;
    logic [2:0]              size_q;
    logic [AddrWidth-1:0]    phy_ptr;
    logic [AddrWidth-1:0]    phy_ptr_inc;
    logic [AxiDataWidth-1:0] buffer;

    logic                    start_read;
    logic                    phy_hs;
    logic                    axi_hs;
    logic                    narrow;
    logic                    next_in_word;

    logic [AddrWidth-1:0]    byte_idx;
    logic [AddrWidth-1:0]    byte_idx_next;
    logic [AddrWidth-1:0]    beat_mask;
    logic [BurstLength-1:0]  beats_left;
    logic                    beats_last;

    assign start_read  = (state == Idle) && trans_handshake && !is_a_write;

    // In Idle any stray PHY word is swallowed so the CDC FIFO drains after the
    // burst has already been completed on the AXI side.
    assign phy_ready_o = collect_q || ((state == Idle) && phy_valid_i);
    assign phy_hs      = collect_q && phy_valid_i;
    assign axi_hs      = axi_valid_o && axi_ready_i;

    assign phy_ptr_inc  = phy_ptr + PhyStep;
    assign narrow       = (size_q <= 3'(PhyLog));
    assign next_in_word = ((byte_idx_next & PhyOffsetMask) != '0);

    assign data_o = buffer;
    assign last_o = axi_valid_o && beats_last;

    hyperbus_axi_beat_cnt #(
        .AddrWidth   (AddrWidth),
        .BurstLength (BurstLength)
    ) i_beat_cnt (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .load          (start_read),
        .step          (axi_hs && !beats_last),
        .start_addr    (start_addr),
        .len           (len),
        .size          (size_q),
        .byte_idx      (byte_idx),
        .byte_idx_next (byte_idx_next),
        .beat_mask     (beat_mask),
        .beats_left    (beats_left),
        .last          (beats_last)
    );

    // NOTE: the AXI-word buffer is reset together with the control state; it
    // drives data_o directly, and data_o must read zero out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= Idle;
            collect_q   <= 1'b0;
            axi_valid_o <= 1'b0;
            size_q      <= '0;
            phy_ptr     <= '0;
            buffer      <= '0;
        end else begin
            unique case (state)
                Idle: begin
                    if (start_read) begin
                        state     <= Collect;
                        collect_q <= 1'b1;
                        size_q    <= size;
                        phy_ptr   <= start_addr & ~PhyOffsetMask;
                    end
                end
                Collect: begin
                    if (phy_hs) begin
                        buffer[int'(phy_ptr) * 8 +: PhyWidth] <= data_i;
                        phy_ptr <= phy_ptr_inc;
                        // Narrow beats fit in one word; wide beats complete
                        // once the write pointer reaches the next beat boundary.
                        if (narrow || ((phy_ptr_inc & beat_mask) == '0)) begin
                            state       <= Send;
                            collect_q   <= 1'b0;
                            axi_valid_o <= 1'b1;
                        end
                    end
                end
                Send: begin
                    if (axi_hs) begin
                        if (beats_last) begin
                            state       <= Idle;
                            axi_valid_o <= 1'b0;
                        end else if (!next_in_word) begin
                            state       <= Collect;
                            collect_q   <= 1'b1;
                            axi_valid_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= Idle;
                    collect_q   <= 1'b0;
                    axi_valid_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef HYPERBUS_PHY2R_ERR_EN
    logic beat_err_q;
    logic early_last_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_err_q   <= 1'b0;
            early_last_q <= 1'b0;
        end else if (start_read) begin
            beat_err_q   <= 1'b0;
            early_last_q <= 1'b0;
        end else if (phy_hs) begin
            // Sticky across every word of a wide beat and every narrow beat
            // carved out of the same word.
            beat_err_q <= beat_err_q || phy_error_i;
            if (last_i && !beats_last) begin
                early_last_q <= 1'b1;
            end
        end else if (axi_hs && !beats_last && !next_in_word) begin
            // Next beat is built from fresh PHY words.
            beat_err_q <= 1'b0;
        end
    end

    assign resp_o = (axi_valid_o && (beat_err_q || (beats_last && early_last_q)))
                    ? AxiRespSlvErr : AxiRespOkay;
`else
    logic unused_last;
    assign unused_last = last_i ^ byte_idx[0] ^ beats_left[0];
`endif

endmodule

// File: tb/tb_hyperbus_phy2r.sv
`timescale 1ns/1ps
module tb_hyperbus_phy2r;
    import hyperbus_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        trans_handshake;
    logic        is_a_write;
    logic [2:0]  size;
    logic [2:0]  start_addr;
    logic [7:0]  len;
    logic        phy_valid_i;
    logic        phy_ready_o;
    logic [31:0] data_i;
    logic        last_i;
    logic        axi_valid_o;
    logic        axi_ready_i;
    logic [63:0] data_o;
    logic        last_o;
`ifdef HYPERBUS_PHY2R_ERR_EN
    logic        phy_error_i;
    logic [1:0]  resp_o;
`endif

    hyperbus_phy2r #(
        .AxiDataWidth (64),
        .BurstLength  (8)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .trans_handshake (trans_handshake),
        .is_a_write      (is_a_write),
        .size            (size),
        .start_addr      (start_addr),
        .len             (len),
        .phy_valid_i     (phy_valid_i),
        .phy_ready_o     (phy_ready_o),
        .data_i          (data_i),
        .last_i          (last_i),
`ifdef HYPERBUS_PHY2R_ERR_EN
        .phy_error_i     (phy_error_i),
        .resp_o          (resp_o),
`endif
        .axi_valid_o     (axi_valid_o),
        .axi_ready_i     (axi_ready_i),
        .data_o          (data_o),
        .last_o          (last_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] data;
        logic [63:0] mask;
        logic        last;
        logic [1:0]  resp;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] phy_q[$];
    int          n_asserts = 0;
    int          n_fails   = 0;
    int          span;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected beat: bytes [lo +: n] of data are the active lanes.
    task automatic push_beat(input logic [63:0] data, input int lo, input int n,
                             input logic last, input logic [1:0] resp);
        beat_t b;
        b.data = data;
        b.mask = '0;
        for (int i = lo; i < lo + n; i++) b.mask[i*8 +: 8] = 8'hFF;
        b.last = last;
        b.resp = resp;
        exp_q.push_back(b);
    endtask

    task automatic drive_phy();
        phy_valid_i = (phy_q.size() > 0);
        data_i      = phy_valid_i ? phy_q[0] : 32'h0;
    endtask

    // Issue a read, feed phy_q, accept R beats and score them against exp_q.
    task automatic run_txn(input logic [2:0] sz, input logic [2:0] sa, input logic [7:0] ln,
                           input int exp_hs, input int stall, input string tag,
                           output int beat_span);
        int          hs = 0;
        int          cyc = 0;
        int          stall_left = stall;
        int          first_beat = -1;
        int          last_beat = -1;
        int          hs_cycle = -1;
        int          hs_before = -1;
        logic [63:0] held = '0;
        logic        held_v = 1'b0;
        logic        phy_fire;
        logic        axi_fire;
        beat_t       b;

        size = sz; start_addr = sa; len = ln; is_a_write = 1'b0;
        trans_handshake = 1'b1;
        @(posedge clk_i); #1;
        trans_handshake = 1'b0;
        drive_phy();
        axi_ready_i = (stall_left == 0);

        while (exp_q.size() > 0 && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
            phy_fire = phy_valid_i && phy_ready_o;
            axi_fire = axi_valid_o && axi_ready_i;
            if (axi_valid_o && first_beat < 0) begin
                first_beat = cyc;
                hs_before  = hs_cycle;
            end
            if (axi_valid_o && !axi_ready_i) begin
                check({tag, " stall phy_ready"}, phy_ready_o, 1'b0);
                if (held_v) check({tag, " stall data"}, data_o, held);
                held   = data_o;
                held_v = 1'b1;
                stall_left--;
            end
            if (axi_fire) begin
                b = exp_q.pop_front();
                check({tag, " data"}, data_o & b.mask, b.data & b.mask);
                check({tag, " last"}, last_o, b.last);
`ifdef HYPERBUS_PHY2R_ERR_EN
                check({tag, " resp"}, resp_o, b.resp);
`endif
                last_beat = cyc;
            end
            if (phy_fire) begin
                hs++;
                hs_cycle = cyc;
            end
            @(posedge clk_i); #1;
            if (phy_fire) void'(phy_q.pop_front());
            drive_phy();
            axi_ready_i = (stall_left <= 0);
        end

        check({tag, " beats outstanding"}, exp_q.size(), 0);
        exp_q.delete();
        check({tag, " phy handshakes"}, hs, exp_hs);
        check({tag, " first beat latency"}, first_beat - hs_before, 1);
        if (stall > 0) check({tag, " stall cycles"}, stall_left, 0);
        beat_span = last_beat - first_beat;
        axi_ready_i = 1'b0;
    endtask

    task automatic case1_words();
        phy_q.push_back(32'h03020100);
        phy_q.push_back(32'h07060504);
        phy_q.push_back(32'h0B0A0908);
        phy_q.push_back(32'h0F0E0D0C);
    endtask

    task automatic case1_beats(input logic [1:0] resp);
        push_beat(64'h0706050403020100, 0, 8, 1'b0, resp);
        push_beat(64'h0F0E0D0C0B0A0908, 0, 8, 1'b1, resp);
    endtask

    task automatic case2_beats(input logic [1:0] resp);
        push_beat(64'h0000_0000_0000_1100, 1, 1, 1'b0, resp);
        push_beat(64'h0000_0000_0022_0000, 2, 1, 1'b0, resp);
        push_beat(64'h0000_0000_3300_0000, 3, 1, 1'b1, resp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        trans_handshake = 1'b0;
        is_a_write = 1'b0;
        size = '0;
        start_addr = '0;
        len = '0;
        phy_valid_i = 1'b0;
        data_i = '0;
        last_i = 1'b0;
        axi_ready_i = 1'b0;
`ifdef HYPERBUS_PHY2R_ERR_EN
        phy_error_i = 1'b0;
`endif
        #1;
        check("reset phy_ready", phy_ready_o, 1'b0);
        check("reset axi_valid", axi_valid_o, 1'b0);
        check("reset last", last_o, 1'b0);
        check("reset data", data_o, 64'h0);
`ifdef HYPERBUS_PHY2R_ERR_EN
        check("reset resp", resp_o, 2'b00);
`endif
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Case 1: wide beats, two PHY words per beat.
        case1_words();
        case1_beats(AxiRespOkay);
        run_txn(3'd3, 3'd0, 8'd1, 4, 0, "c1", span);

        // Case 2: narrow beats from one PHY word; a leftover word follows.
        phy_q.push_back(32'h33221100);
        phy_q.push_back(32'hCAFEF00D);
        case2_beats(AxiRespOkay);
        run_txn(3'd0, 3'd1, 8'd2, 1, 0, "c2", span);
        check("c2 back-to-back span", span, 2);
        check("idle drain ready", phy_ready_o, 1'b1);
        @(posedge clk_i); #1;
        phy_q.delete();
        drive_phy();

        // Case 3: halfword beats, one PHY word each.
        phy_q.push_back(32'hDDCCBBAA);
        phy_q.push_back(32'h44332211);
        push_beat(64'h0000_0000_DDCC_0000, 2, 2, 1'b0, AxiRespOkay);
        push_beat(64'h0000_2211_0000_0000, 4, 2, 1'b1, AxiRespOkay);
        run_txn(3'd1, 3'd2, 8'd1, 2, 0, "c3", span);

        // Case 4: case 1 with beat0 held off for 5 cycles.
        case1_words();
        case1_beats(AxiRespOkay);
        run_txn(3'd3, 3'd0, 8'd1, 4, 5, "c4", span);

        // Case 5: reset in the middle of collecting a wide beat.
        size = 3'd3; start_addr = 3'd0; len = 8'd1;
        trans_handshake = 1'b1;
        @(posedge clk_i); #1;
        trans_handshake = 1'b0;
        phy_valid_i = 1'b1;
        data_i = 32'h55AA55AA;
        @(negedge clk_i);
        check("c5 collect ready", phy_ready_o, 1'b1);
        @(posedge clk_i); #1;
        phy_valid_i = 1'b0;
        check("c5 collect no beat", axi_valid_o, 1'b0);
        rst_i = 1'b1;
        #1;
        check("c5 reset data", data_o, 64'h0);
        check("c5 reset valid", axi_valid_o, 1'b0);
        check("c5 reset phy_ready", phy_ready_o, 1'b0);
        @(posedge clk_i); #1;
        check("c5 reset last", last_o, 1'b0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        phy_q.push_back(32'h33221100);
        case2_beats(AxiRespOkay);
        run_txn(3'd0, 3'd1, 8'd2, 1, 0, "c5 fresh", span);

`ifdef HYPERBUS_PHY2R_ERR_EN
        // Case 6: errored narrow word, then a clean wide burst, then early last_i.
        phy_error_i = 1'b1;
        phy_q.push_back(32'h33221100);
        case2_beats(AxiRespSlvErr);
        run_txn(3'd0, 3'd1, 8'd2, 1, 0, "c6 err", span);
        phy_error_i = 1'b0;
        case1_words();
        case1_beats(AxiRespOkay);
        run_txn(3'd3, 3'd0, 8'd1, 4, 0, "c6 clean", span);
        last_i = 1'b1;
        phy_q.push_back(32'hDDCCBBAA);
        phy_q.push_back(32'h44332211);
        push_beat(64'h0000_0000_DDCC_0000, 2, 2, 1'b0, AxiRespOkay);
        push_beat(64'h0000_2211_0000_0000, 4, 2, 1'b1, AxiRespSlvErr);
        run_txn(3'd1, 3'd2, 8'd1, 2, 0, "c6 early last", span);
        last_i = 1'b0;
`endif

        repeat (2) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
